// File: rtl/mul_pp_tail_pipe_if.sv
// Handshake and data bundle for the partial-product tail adder pipeline.
// The DUT uses the slave modport and the producer/consumer side uses master.
interface mul_pp_tail_pipe_if #(
    parameter int unsigned W = 64
);
    logic           InValid;
    logic           InReady;
    logic [2*W-1:0] SumIn;
    logic [2*W-1:0] CarryIn;
    logic           CorrBit;
    logic           Flush;
    logic           OutValid;
    logic           OutReady;
    logic [2*W-1:0] Product;
    logic           Done;
    logic [3:0]     InFlight;

    modport master (
        output InValid, SumIn, CarryIn, CorrBit, Flush, OutReady,
        input  InReady, OutValid, Product, Done, InFlight
    );

    modport slave (
        input  InValid, SumIn, CarryIn, CorrBit, Flush, OutReady,
        output InReady, OutValid, Product, Done, InFlight
    );
endinterface

// File: rtl/mul_pp_tail_pipe.sv
// Multiplier tail: 3:2 compression of sum/carry/correction, optional delay stages,
// then a carry-propagate add into a registered Product with valid/ready flow control.
module mul_pp_tail_pipe #(
    parameter int unsigned W        = 64,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CORR_POS = W - 2
) (
    input logic               Clk,
    input logic               Rst,
    mul_pp_tail_pipe_if.slave bus
);
    localparam int unsigned PW = 2 * W;

    // vldQ[0] belongs to the compression stage, vldQ[STAGES-1] to Product.
    logic [STAGES-1:0] vldQ;
    logic [PW-1:0]     sumQ   [STAGES-1];
    logic [PW-1:0]     carryQ [STAGES-1];
    logic [PW-1:0]     productQ;
    logic              doneQ;
    logic [3:0]        inFlight;

    logic          stall;
    logic          advance;
    logic          accept;
    logic [PW-1:0] corrVec;
    logic [PW-1:0] csaSum;
    logic [PW-1:0] csaCarry;

    // A stalled output freezes the whole pipe, bubbles included.
    assign stall   = vldQ[STAGES-1] && !bus.OutReady;
    assign advance = !stall;
    assign bus.InReady = advance && !bus.Flush;
    assign accept  = bus.InValid && bus.InReady;

    assign corrVec  = PW'(bus.CorrBit) << CORR_POS;
    assign csaSum   = bus.SumIn ^ bus.CarryIn ^ corrVec;
    assign csaCarry = ((bus.SumIn & bus.CarryIn) | (bus.SumIn & corrVec)
                      | (bus.CarryIn & corrVec)) << 1;

    always_ff @(posedge Clk) begin
        if (advance) begin
            sumQ[0]   <= csaSum;
            carryQ[0] <= csaCarry;
            for (int i = 1; i < int'(STAGES) - 1; i++) begin
                sumQ[i]   <= sumQ[i-1];
                carryQ[i] <= carryQ[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            vldQ     <= '0;
            productQ <= '0;
            doneQ    <= 1'b0;
        end else begin
            // A handshake in the flush cycle still completes and reports Done.
            doneQ <= vldQ[STAGES-1] && bus.OutReady;
            if (bus.Flush) begin
                vldQ <= '0;
            end else if (advance) begin
                vldQ <= {vldQ[STAGES-2:0], accept};
            end
            if (advance) begin
                productQ <= sumQ[STAGES-2] + carryQ[STAGES-2];
            end
        end
    end

    always_comb begin
        inFlight = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            inFlight = inFlight + 4'(vldQ[i]);
        end
    end

    assign bus.OutValid = vldQ[STAGES-1];
    assign bus.Product  = productQ;
    assign bus.Done     = doneQ;
    assign bus.InFlight = inFlight;
endmodule
